// File: rtl/imc_result_stream.sv
// imc_result_stream
//   Output stage of the Inverse Matrix Calculator. Captures four result
//   magnitudes plus sign bits on a load pulse, converts each to two's
//   complement and streams them out in order a, b, c, d over valid/ready.
//   Counts fully transferred packets.
// Ports:
//   clk_i, rst_ni         clock, synchronous active-low reset
//   load_i                one-cycle capture pulse (honoured only when load_ready_o)
//   a_i..d_i, *_sign_i    result magnitudes and signs (1 = negative)
//   load_ready_o          high while idle
//   valid_o, ready_i      output handshake
//   data_o, idx_o, last_o signed word, entry index (0=a..3=d), last-entry flag
//   drop_o                sticky: a load arrived while streaming
//   pkt_cnt_o             completed packet count, wraps

// Per-entry magnitude/sign to two's complement; wraps, no saturation.
module imc_sign_conv #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] mag_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] data_o
);
  assign data_o = sign_i ? (~mag_i + WIDTH'(1)) : mag_i;
endmodule

module imc_result_stream #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             a_sign_i,
  input  logic             b_sign_i,
  input  logic             c_sign_i,
  input  logic             d_sign_i,
  output logic             load_ready_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       idx_o,
  output logic             last_o,
  output logic             drop_o,
  output logic [CNT_W-1:0] pkt_cnt_o
);
  localparam int NUM_LANES = 4;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                            state_q, state_d;
  logic [1:0]                        idx_q, idx_d;
  logic [NUM_LANES-1:0][WIDTH-1:0]   mag_q, conv;
  logic [NUM_LANES-1:0]              sgn_q;
  logic                              drop_q;
  logic [CNT_W-1:0]                  cnt_q;

  logic [NUM_LANES-1:0][WIDTH-1:0]   mag_in;
  logic [NUM_LANES-1:0]              sgn_in;
  logic                              load_fire, pkt_done;

  assign mag_in = {d_i, c_i, b_i, a_i};
  assign sgn_in = {d_sign_i, c_sign_i, b_sign_i, a_sign_i};

  assign load_fire = (state_q == IDLE) && load_i;
  assign pkt_done  = (state_q == SEND) && ready_i && (idx_q == 2'd3);

  // Conversion works from the captured copy, so the datapath is free
  // to change its outputs the cycle after load.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    imc_sign_conv #(.WIDTH(WIDTH)) u_conv (
      .mag_i  (mag_q[l]),
      .sign_i (sgn_q[l]),
      .data_o (conv[l])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (load_i) begin
          state_d = SEND;
          idx_d   = 2'd0;
        end
      end
      SEND: begin
        if (ready_i) begin
          if (idx_q == 2'd3) begin
            state_d = IDLE;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      mag_q   <= '0;
      sgn_q   <= '0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load_fire) begin
        mag_q <= mag_in;
        sgn_q <= sgn_in;
      end
      // Includes a load coinciding with the final handshake: still busy.
      if ((state_q == SEND) && load_i) drop_q <= 1'b1;
      if (pkt_done) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Outputs depend on registered state only; ready_i never reaches valid_o.
  assign load_ready_o = (state_q == IDLE);
  assign valid_o      = (state_q == SEND);
  assign data_o       = valid_o ? conv[idx_q] : '0;
  assign idx_o        = valid_o ? idx_q : 2'd0;
  assign last_o       = valid_o && (idx_q == 2'd3);
  assign drop_o       = drop_q;
  assign pkt_cnt_o    = cnt_q;

endmodule

// File: tb/tb_imc_result_stream.sv
module tb_imc_result_stream;
  localparam int W  = 16;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          load_i;
  logic [W-1:0]  a_i, b_i, c_i, d_i;
  logic          a_sign_i, b_sign_i, c_sign_i, d_sign_i;
  logic          load_ready_o, valid_o, ready_i, last_o, drop_o;
  logic [W-1:0]  data_o;
  logic [1:0]    idx_o;
  logic [CW-1:0] pkt_cnt_o;

  imc_result_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .load_i(load_i),
    .a_i(a_i), .b_i(b_i), .c_i(c_i), .d_i(d_i),
    .a_sign_i(a_sign_i), .b_sign_i(b_sign_i), .c_sign_i(c_sign_i), .d_sign_i(d_sign_i),
    .load_ready_o(load_ready_o), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .idx_o(idx_o), .last_o(last_o),
    .drop_o(drop_o), .pkt_cnt_o(pkt_cnt_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A packet is just four pending words in a queue; the block is busy
  // whenever words remain to be transferred.
  typedef struct { logic [W-1:0] data; int idx; } word_t;
  word_t   mq[$];
  int      m_cnt  = 0;
  bit      m_drop = 0;

  function automatic logic [W-1:0] to_signed(input logic [W-1:0] mag, input logic s);
    int unsigned v;
    v = s ? ((32'h1 << W) - mag) : mag;
    return v[W-1:0];
  endfunction

  always @(posedge clk) begin
    if (!rst_ni) begin
      mq.delete();
      m_cnt  = 0;
      m_drop = 0;
    end else begin
      bit busy;
      word_t w;
      busy = (mq.size() != 0);
      if (busy && ready_i) begin
        w = mq.pop_front();
        if (w.idx == 3) m_cnt = (m_cnt + 1) % (1 << CW);
      end
      if (load_i) begin
        if (busy) m_drop = 1;
        else begin
          mq.push_back('{to_signed(a_i, a_sign_i), 0});
          mq.push_back('{to_signed(b_i, b_sign_i), 1});
          mq.push_back('{to_signed(c_i, c_sign_i), 2});
          mq.push_back('{to_signed(d_i, d_sign_i), 3});
        end
      end
    end
  end

  always @(negedge clk) begin
    bit busy;
    busy = (mq.size() != 0);
    chk("load_ready", load_ready_o, !busy);
    chk("valid",      valid_o, busy);
    chk("data",       data_o, busy ? mq[0].data : '0);
    chk("idx",        idx_o,  busy ? mq[0].idx : 0);
    chk("last",       last_o, busy && mq[0].idx == 3);
    chk("drop",       drop_o, m_drop);
    chk("pkt_cnt",    pkt_cnt_o, m_cnt);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic load_pkt(input logic [W-1:0] a, input logic as_, input logic [W-1:0] b, input logic bs,
                          input logic [W-1:0] c, input logic cs, input logic [W-1:0] d, input logic ds);
    cyc();
    load_i = 1; a_i = a; b_i = b; c_i = c; d_i = d;
    a_sign_i = as_; b_sign_i = bs; c_sign_i = cs; d_sign_i = ds;
    cyc();
    load_i = 0;
    // datapath is free to move on once captured
    a_i = W'($urandom); b_i = W'($urandom); c_i = W'($urandom); d_i = W'($urandom);
    {a_sign_i, b_sign_i, c_sign_i, d_sign_i} = 4'($urandom);
  endtask

  task automatic expect4(input string nm, input logic [W-1:0] e0, input logic [W-1:0] e1,
                         input logic [W-1:0] e2, input logic [W-1:0] e3);
    logic [W-1:0] e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk({nm, "_data"}, data_o, e[k]);
      chk({nm, "_idx"},  idx_o, k);
      chk({nm, "_last"}, last_o, k == 3);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (mq.size() != 0 && n < 60) begin cyc(); n++; end
    if (n >= 60) begin
      n_chk++; n_err++;
      $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", nm, n);
    end
  endtask

  initial begin
    logic [4:0] pat;
    pat = 5'b10100;  // bit i = ready in cycle i: 0,0,1,0,1
    rst_ni = 0; load_i = 0; ready_i = 0;
    a_i = 0; b_i = 0; c_i = 0; d_i = 0;
    a_sign_i = 0; b_sign_i = 0; c_sign_i = 0; d_sign_i = 0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1;
    @(negedge clk);
    chk("rst_load_ready", load_ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_cnt", pkt_cnt_o, 0);

    // basic packet
    ready_i = 1;
    load_pkt(16'h0100, 0, 16'h0020, 1, 16'h0003, 1, 16'h7FFF, 0);
    expect4("basic", 16'h0100, 16'hFFE0, 16'hFFFD, 16'h7FFF);
    @(negedge clk);
    chk("basic_cnt", pkt_cnt_o, 1);
    chk("basic_idle", valid_o, 0);

    // backpressure
    ready_i = 0;
    load_pkt(16'h0100, 0, 16'h0020, 1, 16'h0003, 1, 16'h7FFF, 0);
    for (int i = 0; i < 60 && mq.size() != 0; i++) begin
      ready_i = pat[i % 5];
      cyc();
    end
    ready_i = 1;
    wait_idle("bp");
    @(negedge clk);
    chk("bp_cnt", pkt_cnt_o, 2);

    // sign edge cases
    load_pkt(16'h0000, 1, 16'h8000, 1, 16'hFFFF, 0, 16'h0001, 1);
    expect4("sign", 16'h0000, 16'h8000, 16'hFFFF, 16'hFFFF);
    @(negedge clk);
    chk("sign_cnt", pkt_cnt_o, 3);

    // load while busy: during word b and on the word-d handshake
    load_pkt(16'h1234, 0, 16'h0001, 1, 16'h00FF, 0, 16'h0002, 1);  // now in cycle of word a
    cyc();                                                          // word b
    load_i = 1; a_i = 16'hAAAA; b_i = 16'hBBBB;
    cyc();                                                          // word c
    load_i = 0;
    cyc();                                                          // word d
    load_i = 1; c_i = 16'hCCCC;
    cyc();
    load_i = 0;
    @(negedge clk);
    chk("busy_drop", drop_o, 1);
    chk("busy_valid", valid_o, 0);
    chk("busy_cnt", pkt_cnt_o, 0);   // fourth packet wraps the 2-bit counter
    repeat (3) cyc();
    chk("busy_drop_sticky", drop_o, 1);

    // reset mid-packet, after word b accepted
    load_pkt(16'h0005, 0, 16'h0006, 0, 16'h0007, 0, 16'h0008, 0);
    cyc();                 // edge: a accepted, word b shown
    cyc();                 // edge: b accepted
    rst_ni = 0;
    cyc();
    rst_ni = 1;
    @(negedge clk);
    chk("rst_mid_valid", valid_o, 0);
    chk("rst_mid_ready", load_ready_o, 1);
    chk("rst_mid_cnt", pkt_cnt_o, 0);
    chk("rst_mid_drop", drop_o, 0);
    load_pkt(16'h0009, 1, 16'h000A, 0, 16'h000B, 1, 16'h000C, 0);
    expect4("fresh", 16'hFFF7, 16'h000A, 16'hFFF5, 16'h000C);

    // counter wrap: 1,2,3,0,1 from reset
    for (int p = 0; p < 5; p++) begin
      logic [CW-1:0] e;
      e = CW'(p + 1);
      if (p == 0) begin
        @(negedge clk);
        chk("wrap_cnt", pkt_cnt_o, e);
      end else begin
        load_pkt(W'(p), p[0], W'(p * 3), 0, W'(p * 5), 1, W'(p * 7), 0);
        wait_idle("wrap");
        @(negedge clk);
        chk("wrap_cnt", pkt_cnt_o, e);
      end
    end

    repeat (2) cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
